vga_rx_capture: RTL and testbench
=================================

Name: vga_rx_capture

Overview:
- Receive side of the VGA pixel interface. Consumes the hs/vs/RGB stream that the display pipeline generates.
- Recovers pixel coordinates from the sync edges and checks the timing against the nominal 640x480@60 geometry.
- Emits per-pixel valid strobes with x/y/RGB once locked. Feeds frame-buffer writers and the self-check bench harness.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_SYNC, 96, hs pulse width in pixels
- H_BP, 48, horizontal back porch
- H_TOTAL, 800, pixels per line
- V_ACTIVE, 480, visible lines per frame
- V_SYNC, 2, vs pulse width in lines
- V_BP, 33, vertical back porch
- V_TOTAL, 525, lines per frame

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous to clk_i, active-high
- pxl_en_i  in  1  pixel strobe; all stream inputs are sampled only when 1
- hs_i  in  1  horizontal sync, active-low
- vs_i  in  1  vertical sync, active-low
- r_i, g_i, b_i  in  8 each  pixel colour
- pix_valid_o  out  1  one-cycle pulse per captured active pixel
- x_o  out  10  column of captured pixel, 0..H_ACTIVE-1
- y_o  out  10  row of captured pixel, 0..V_ACTIVE-1
- pix_o  out  24  {r,g,b} of captured pixel
- frame_start_o  out  1  pulse coincident with pix_valid_o for x=0, y=0
- locked_o  out  1  level; timing verified
- err_o  out  1  one-cycle pulse on timing violation while locked or aligning

Behaviour:
- Reset: all outputs 0; state SEARCH; h_cnt=v_cnt=0; previous hs/vs registers = 1 (deasserted).
- Sample definition: a cycle with pxl_en_i=1. Nothing advances on other cycles; outputs are held and pulses drop to 0.
- hs edge: a sample where hs_i=0 and the previous sample's hs_i=1.
- h_cnt:
  - On an hs edge sample: h_cnt becomes 0.
  - On any other sample: h_cnt increments, saturating at 1023.
  - The value assigned to a sample is that sample's h index.
- v_cnt is updated only on hs edge samples:
  - If vs_i=0 and vs was 1 at the previous hs edge: v_cnt becomes 0 (vs edge).
  - Otherwise v_cnt increments, saturating at 1023.
- Line check: on each hs edge, the pre-reset h_cnt must equal H_TOTAL-1.
- Frame check: on each vs edge, the pre-reset v_cnt must equal V_TOTAL-1.
- FSM:
  - SEARCH: on a vs edge, go to ALIGN; the frame check is ignored on this edge.
  - ALIGN: a line check failure pulses err_o and restarts ALIGN (measurement continues from the next vs edge). On a vs edge, a passing frame check with no line failures in that frame goes to LOCKED; a failing check pulses err_o and stays in ALIGN.
  - LOCKED: any failing line or frame check pulses err_o, goes to SEARCH, and clears locked_o in the same cycle as err_o.
- locked_o = 1 exactly while in LOCKED; it rises the cycle after the qualifying vs edge sample.
- Active window: h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
- Pixel output, latency 1 cycle: for an active sample in LOCKED at cycle k, at cycle k+1:
  - pix_valid_o=1
  - x_o = h-(H_SYNC+H_BP), y_o = v-(V_SYNC+V_BP)
  - pix_o = {r_i,g_i,b_i} as sampled at k
  - x_o/y_o/pix_o hold their values until the next valid pixel.
- Simultaneous events: the same sample that causes the LOCKED→SEARCH error produces no pixel. A vs edge and an hs edge on the same sample are normal; the frame check is evaluated first.
- Saturated counters (hs/vs absent) never match the check values; this is detected at the next edge.
- rst_i mid-frame returns to SEARCH in one cycle, regardless of pxl_en_i.

Optional Feature:
- Macro: VGA_RX_CRC_EN.
- When defined, adds outputs crc_o (16) and crc_valid_o (1):
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) accumulated over pix_o, in order r, g, b, for every pixel_valid pixel.
  - The CRC resets at frame_start_o.
  - On the first vs edge after the final active pixel (x=639, y=479), crc_o is latched and crc_valid_o pulses for one cycle.
- When undefined: the ports and logic are absent.

Test Plan:
- Ideal 640x480 stream, pxl_en_i every cycle, 3 frames:
  - locked_o rises after frame 2's opening vs edge.
  - Frame 2 gives 307200 pix_valid_o pulses; the first has x=0, y=0 with frame_start_o=1; the last has x=639, y=479.
  - err_o never pulses.
- pxl_en_i every 2nd cycle, pixel = {x[7:0], y[7:0], 8'h5A}: every capture has pix_o matching {x_o[7:0], y_o[7:0], 8'h5A}; 0 mismatches.
- Locked, then one line with 799 pixels:
  - err_o pulses once at that hs edge; locked_o drops the same cycle.
  - No pix_valid_o until relock, which takes 1 full good frame after the next vs edge.
- Frame of 524 lines during ALIGN: err_o pulses at the vs edge; locked_o stays 0; the next clean frame locks.
- rst_i asserted for 1 cycle at x=320, y=240 while locked: next cycle all outputs 0; relock follows the normal SEARCH→ALIGN→LOCKED sequence.
- VGA_RX_CRC_EN, constant pixel 0x000000 frame: crc_valid_o pulses once per frame; crc_o equals the golden-model CRC of 921600 zero bytes and is identical across 2 frames.

Source files
------------

// File: rtl/vga_rx_capture.sv
// VGA receive side: recovers pixel coordinates from hs/vs edges, locks onto the nominal
// timing and emits captured pixels. Define VGA_RX_CRC_EN to add a per-frame CRC-16 of captured pixels.
module vga_rx_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pxl_en_i,
    input  logic        hs_i,
    input  logic        vs_i,
    input  logic [7:0]  r_i,
    input  logic [7:0]  g_i,
    input  logic [7:0]  b_i,
    output logic        pix_valid_o,
    output logic [9:0]  x_o,
    output logic [9:0]  y_o,
    output logic [23:0] pix_o,
    output logic        frame_start_o,
    output logic        locked_o,
    output logic        err_o
`ifdef VGA_RX_CRC_EN
    ,
    output logic [15:0] crc_o,
    output logic        crc_valid_o
`endif
);

    localparam logic [9:0] L_H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] L_V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] L_H_LO   = 10'(H_SYNC + H_BP);
    localparam logic [9:0] L_H_HI   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] L_V_LO   = 10'(V_SYNC + V_BP);
    localparam logic [9:0] L_V_HI   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [9:0] L_SAT    = 10'h3FF;

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t     r_state;
    logic [9:0] r_h_cnt, r_v_cnt;
    logic       r_hs_prev, r_vs_prev, r_line_bad;

    logic       w_hs_edge, w_vs_edge, w_line_fail, w_frame_fail, w_active;
    logic [9:0] w_h_nxt, w_v_nxt, w_x, w_y;

    assign w_hs_edge    = pxl_en_i & ~hs_i & r_hs_prev;
    // vs is only qualified at hs edges, against its value at the previous hs edge
    assign w_vs_edge    = w_hs_edge & ~vs_i & r_vs_prev;
    assign w_h_nxt      = w_hs_edge ? 10'd0 : (r_h_cnt == L_SAT) ? r_h_cnt : r_h_cnt + 10'd1;
    assign w_v_nxt      = !w_hs_edge ? r_v_cnt : w_vs_edge ? 10'd0 :
                          (r_v_cnt == L_SAT) ? r_v_cnt : r_v_cnt + 10'd1;
    assign w_line_fail  = w_hs_edge && (r_h_cnt != L_H_LAST);
    assign w_frame_fail = w_vs_edge && (r_v_cnt != L_V_LAST);
    assign w_active     = (w_h_nxt >= L_H_LO) && (w_h_nxt <= L_H_HI) &&
                          (w_v_nxt >= L_V_LO) && (w_v_nxt <= L_V_HI);
    assign w_x          = w_h_nxt - L_H_LO;
    assign w_y          = w_v_nxt - L_V_LO;

`ifdef VGA_RX_CRC_EN
    localparam logic [9:0] L_X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] L_Y_LAST = 10'(V_ACTIVE - 1);

    logic [15:0] r_crc_acc;
    logic        r_crc_pend;
    logic [15:0] w_crc_seed, w_crc_nxt;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] t;
        t = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) t = t[15] ? ((t << 1) ^ 16'h1021) : (t << 1);
        return t;
    endfunction

    assign w_crc_seed = (w_x == 10'd0 && w_y == 10'd0) ? 16'hFFFF : r_crc_acc;
    assign w_crc_nxt  = crc_byte(crc_byte(crc_byte(w_crc_seed, r_i), g_i), b_i);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= SEARCH;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hs_prev     <= 1'b1;
            r_vs_prev     <= 1'b1;
            r_line_bad    <= 1'b0;
            pix_valid_o   <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
            pix_o         <= '0;
            frame_start_o <= 1'b0;
            locked_o      <= 1'b0;
            err_o         <= 1'b0;
`ifdef VGA_RX_CRC_EN
            r_crc_acc     <= 16'hFFFF;
            r_crc_pend    <= 1'b0;
            crc_o         <= '0;
            crc_valid_o   <= 1'b0;
`endif
        end else begin
            pix_valid_o   <= 1'b0;
            frame_start_o <= 1'b0;
            err_o         <= 1'b0;
`ifdef VGA_RX_CRC_EN
            crc_valid_o   <= 1'b0;
`endif
            if (pxl_en_i) begin
                r_hs_prev <= hs_i;
                if (w_hs_edge) r_vs_prev <= vs_i;
                r_h_cnt <= w_h_nxt;
                r_v_cnt <= w_v_nxt;
                case (r_state)
                    SEARCH: begin
                        if (w_vs_edge) begin
                            r_state    <= ALIGN;
                            r_line_bad <= 1'b0;
                        end
                    end
                    ALIGN: begin
                        // frame check first; a line failure earlier in the frame blocks lock
                        if (w_vs_edge) begin
                            if (w_frame_fail || w_line_fail) begin
                                err_o <= 1'b1;
                            end else if (!r_line_bad) begin
                                r_state  <= LOCKED;
                                locked_o <= 1'b1;
                            end
                            r_line_bad <= 1'b0;
                        end else if (w_line_fail) begin
                            err_o      <= 1'b1;
                            r_line_bad <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (w_frame_fail || w_line_fail) begin
                            err_o    <= 1'b1;
                            r_state  <= SEARCH;
                            locked_o <= 1'b0;
                        end else if (w_active) begin
                            pix_valid_o   <= 1'b1;
                            x_o           <= w_x;
                            y_o           <= w_y;
                            pix_o         <= {r_i, g_i, b_i};
                            frame_start_o <= (w_x == 10'd0) && (w_y == 10'd0);
`ifdef VGA_RX_CRC_EN
                            r_crc_acc <= w_crc_nxt;
                            if (w_x == L_X_LAST && w_y == L_Y_LAST) r_crc_pend <= 1'b1;
`endif
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
`ifdef VGA_RX_CRC_EN
                if (w_vs_edge && r_crc_pend) begin
                    crc_o       <= r_crc_acc;
                    crc_valid_o <= 1'b1;
                    r_crc_pend  <= 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_capture.sv
// Bench for vga_rx_capture on a reduced geometry: frame-level stream generator with a
// line/frame-length reference model; CRC section active when VGA_RX_CRC_EN is defined.
module tb_vga_rx_capture;
    localparam int HA = 16, HS = 4, HBP = 3, HT = 28;
    localparam int VA = 8,  VS = 2, VBP = 3, VT = 16;
    localparam int XO = HS + HBP, YO = VS + VBP;

    logic        clk = 1'b0;
    logic        rst, en, hs, vs;
    logic [7:0]  r, g, b;
    logic        pix_valid_o, frame_start_o, locked_o, err_o;
    logic [9:0]  x_o, y_o;
    logic [23:0] pix_o;
`ifdef VGA_RX_CRC_EN
    logic [15:0] crc_o;
    logic        crc_valid_o;
`endif

    always #5 clk = ~clk;

    vga_rx_capture #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HBP), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VBP), .V_TOTAL(VT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pxl_en_i(en), .hs_i(hs), .vs_i(vs),
        .r_i(r), .g_i(g), .b_i(b),
        .pix_valid_o(pix_valid_o), .x_o(x_o), .y_o(y_o), .pix_o(pix_o),
        .frame_start_o(frame_start_o), .locked_o(locked_o), .err_o(err_o)
`ifdef VGA_RX_CRC_EN
        , .crc_o(crc_o), .crc_valid_o(crc_valid_o)
`endif
    );

    int n_chk = 0, n_fail = 0;
    int gap_mode = 0, pix_mode = 0;
    int g_prev_len = 0, g_prev_lines = 0;
    int cnt_valid, cnt_fs, cnt_err;
    bit seen_first;
    logic [9:0] first_x, first_y;

    // reference model: mode 0 searching, 1 aligning, 2 locked
    int          m_mode;
    bit          m_bad;
    bit          e_valid, e_fs, e_lock, e_err;
    logic [9:0]  e_x, e_y;
    logic [23:0] e_pix;

`ifdef VGA_RX_CRC_EN
    logic [15:0] m_crc, e_crc, crc_last, crc_prev, golden;
    bit          m_pend, e_crcv;
    int          crcv_cnt;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] t;
        t = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) t = t[15] ? ((t << 1) ^ 16'h1021) : (t << 1);
        return t;
    endfunction
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("pix_valid", 32'(pix_valid_o), 32'(e_valid));
        chk("x", 32'(x_o), 32'(e_x));
        chk("y", 32'(y_o), 32'(e_y));
        chk("pix", 32'(pix_o), 32'(e_pix));
        chk("frame_start", 32'(frame_start_o), 32'(e_fs));
        chk("locked", 32'(locked_o), 32'(e_lock));
        chk("err", 32'(err_o), 32'(e_err));
`ifdef VGA_RX_CRC_EN
        chk("crc_valid", 32'(crc_valid_o), 32'(e_crcv));
        chk("crc", 32'(crc_o), 32'(e_crc));
        if (crc_valid_o) begin
            crcv_cnt++;
            crc_prev = crc_last;
            crc_last = crc_o;
        end
`endif
        if (pix_mode == 1 && pix_valid_o)
            chk("pattern", 32'(pix_o), 32'({x_o[7:0], y_o[7:0], 8'h5A}));
        cnt_valid += int'(pix_valid_o);
        cnt_fs    += int'(frame_start_o);
        cnt_err   += int'(err_o);
        if (pix_valid_o && !seen_first) begin
            seen_first = 1'b1;
            first_x = x_o;
            first_y = y_o;
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_bad = 1'b0;
        e_valid = 0; e_fs = 0; e_err = 0; e_lock = 0;
        e_x = '0; e_y = '0; e_pix = '0;
`ifdef VGA_RX_CRC_EN
        m_crc = 16'hFFFF; m_pend = 0; e_crc = '0; e_crcv = 0;
`endif
    endtask

    task automatic idle_cycle();
        en = 1'b0; rst = 1'b0;
        hs = 1'($urandom); vs = 1'($urandom);
        {r, g, b} = 24'($urandom);
        e_valid = 0; e_fs = 0; e_err = 0;
`ifdef VGA_RX_CRC_EN
        e_crcv = 0;
`endif
        tick();
    endtask

    task automatic reset_pulse();
        en = 1'b0; rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    // one stream sample at pixel p of line l; do_rst asserts rst_i on that sample
    task automatic sample(input int p, input int l, input bit do_rst);
        bit lf, ff, was_locked, fail;
        if (gap_mode == 1) idle_cycle();
        else if (gap_mode == 2) repeat ($urandom_range(0, 2)) idle_cycle();
        en = 1'b1; rst = do_rst;
        hs = (p < HS) ? 1'b0 : 1'b1;
        vs = (l < VS) ? 1'b0 : 1'b1;
        case (pix_mode)
            0:       {r, g, b} = 24'($urandom);
            1:       begin r = 8'(p - XO); g = 8'(l - YO); b = 8'h5A; end
            default: {r, g, b} = 24'h0;
        endcase
        if (do_rst) begin
            model_reset();
        end else begin
            e_valid = 0; e_fs = 0; e_err = 0; fail = 0;
`ifdef VGA_RX_CRC_EN
            e_crcv = 0;
`endif
            was_locked = (m_mode == 2);
            if (p == 0) begin
                lf = (g_prev_len != HT);
                ff = (l == 0) && (g_prev_lines != VT);
                case (m_mode)
                    0: if (l == 0) begin m_mode = 1; m_bad = 0; end
                    1: if (l == 0) begin
                           if (ff || lf) e_err = 1;
                           else if (!m_bad) m_mode = 2;
                           m_bad = 0;
                       end else if (lf) begin
                           e_err = 1; m_bad = 1;
                       end
                    default: if (ff || lf) begin e_err = 1; m_mode = 0; fail = 1; end
                endcase
`ifdef VGA_RX_CRC_EN
                if (l == 0 && m_pend) begin
                    e_crcv = 1; e_crc = m_crc; m_pend = 0;
                end
`endif
            end
            if (was_locked && !fail && p >= XO && p < XO + HA && l >= YO && l < YO + VA) begin
                e_valid = 1;
                e_x = 10'(p - XO);
                e_y = 10'(l - YO);
                e_pix = {r, g, b};
                e_fs = (p == XO) && (l == YO);
`ifdef VGA_RX_CRC_EN
                if (e_fs) m_crc = 16'hFFFF;
                m_crc = crc_byte(crc_byte(crc_byte(m_crc, r), g), b);
                if (p == XO + HA - 1 && l == YO + VA - 1) m_pend = 1;
`endif
            end
            e_lock = (m_mode == 2);
        end
        tick();
        rst = 1'b0;
    endtask

    // nlines lines; line short_l is one pixel short; rst_i pulses at (rst_p, rst_l)
    task automatic send_frame(input int nlines, input int short_l, input int rst_l, input int rst_p);
        int len;
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_l) ? HT - 1 : HT;
            for (int p = 0; p < len; p++) sample(p, l, (l == rst_l) && (p == rst_p));
            g_prev_len = len;
        end
        g_prev_lines = nlines;
    endtask

    task automatic clear_counts();
        cnt_valid = 0; cnt_fs = 0; cnt_err = 0; seen_first = 0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; hs = 1'b1; vs = 1'b1; {r, g, b} = '0;
        model_reset();
        clear_counts();
`ifdef VGA_RX_CRC_EN
        crcv_cnt = 0; crc_last = '0; crc_prev = '0;
`endif
        repeat (3) tick();
        chk("reset_locked", 32'(locked_o), 32'd0);
        rst = 1'b0;

        // ideal stream, three frames: lock at second frame's opening edge
        send_frame(VT, -1, -1, -1);
        chk("t1_unlocked_f0", 32'(locked_o), 32'd0);
        clear_counts();
        send_frame(VT, -1, -1, -1);
        chk("t1_locked_f1", 32'(locked_o), 32'd1);
        chk("t1_pix_count", 32'(cnt_valid), 32'(HA * VA));
        chk("t1_fs_count", 32'(cnt_fs), 32'd1);
        chk("t1_first_x", 32'(first_x), 32'd0);
        chk("t1_first_y", 32'(first_y), 32'd0);
        chk("t1_last_x", 32'(x_o), 32'(HA - 1));
        chk("t1_last_y", 32'(y_o), 32'(VA - 1));
        send_frame(VT, -1, -1, -1);
        chk("t1_err_none", 32'(cnt_err), 32'd0);

        // every other cycle a sample, coordinate-pattern pixels
        gap_mode = 1; pix_mode = 1;
        clear_counts();
        send_frame(VT, -1, -1, -1);
        chk("t2_pix_count", 32'(cnt_valid), 32'(HA * VA));

        // locked, one short line mid-frame, then relock
        gap_mode = 2; pix_mode = 0;
        clear_counts();
        send_frame(VT, 9, -1, -1);
        chk("t3_err_once", 32'(cnt_err), 32'd1);
        chk("t3_unlocked", 32'(locked_o), 32'd0);
        clear_counts();
        send_frame(VT, -1, -1, -1);
        chk("t3_no_pix_align", 32'(cnt_valid), 32'd0);
        chk("t3_still_unlocked", 32'(locked_o), 32'd0);
        send_frame(VT, -1, -1, -1);
        chk("t3_relocked", 32'(locked_o), 32'd1);
        chk("t3_pix_count", 32'(cnt_valid), 32'(HA * VA));

        // reset mid-frame at the centre pixel, then the normal lock sequence
        gap_mode = 0;
        send_frame(VT, -1, YO + VA / 2, XO + HA / 2);
        chk("t4_unlocked", 32'(locked_o), 32'd0);
        send_frame(VT, -1, -1, -1);
        chk("t4_aligning", 32'(locked_o), 32'd0);
        send_frame(VT, -1, -1, -1);
        chk("t4_relocked", 32'(locked_o), 32'd1);

        // short frame measured while aligning
        reset_pulse();
        clear_counts();
        send_frame(VT - 1, -1, -1, -1);
        send_frame(VT, -1, -1, -1);
        chk("t5_err_once", 32'(cnt_err), 32'd1);
        chk("t5_unlocked", 32'(locked_o), 32'd0);
        send_frame(VT, -1, -1, -1);
        chk("t5_locked", 32'(locked_o), 32'd1);
        chk("t5_err_total", 32'(cnt_err), 32'd1);

`ifdef VGA_RX_CRC_EN
        // all-zero frames: each captured frame's CRC equals the zero-byte golden value
        golden = 16'hFFFF;
        for (int i = 0; i < HA * VA * 3; i++) golden = crc_byte(golden, 8'h00);
        pix_mode = 2;
        crcv_cnt = 0;
        send_frame(VT, -1, -1, -1);
        send_frame(VT, -1, -1, -1);
        send_frame(VT, -1, -1, -1);
        chk("crc_pulses", 32'(crcv_cnt), 32'd3);
        chk("crc_frame_a", 32'(crc_prev), 32'(golden));
        chk("crc_frame_b", 32'(crc_last), 32'(golden));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
